// File: rtl/reg_write_arbiter.sv
// Round-robin write-port controller for one shared datapath register.
// A winner is latched in IDLE and committed to q on the following WRITE cycle.
module reg_write_arbiter #(
    parameter int DATAWIDTH = 8,
    parameter int NUM_REQ   = 4,
    localparam int IDW      = $clog2(NUM_REQ)
) (
    input  logic                         Clk,
    input  logic                         Rst,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATAWIDTH-1:0] wr_data,
    output logic [NUM_REQ-1:0]           grant,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATAWIDTH-1:0]         q,
    output logic                         q_valid,
    output logic [IDW-1:0]               last_id,
    output logic                         busy
);

    typedef enum logic {S_IDLE, S_WRITE} state_t;

    state_t               r_state;
    state_t               w_next_state;
    logic [IDW-1:0]       r_ptr;
    logic [IDW-1:0]       r_hold_id;
    logic [DATAWIDTH-1:0] r_hold_data;
    logic [NUM_REQ-1:0]   r_grant;
    logic [DATAWIDTH-1:0] r_q;
    logic                 r_q_valid;
    logic [IDW-1:0]       r_last_id;

    logic                 w_found;
    logic [IDW-1:0]       w_win;
    logic [IDW:0]         w_idx;
    logic [IDW:0]         w_ptr_inc;
    logic [IDW-1:0]       w_ptr_next;
    logic [NUM_REQ-1:0]   w_onehot;
    logic [DATAWIDTH-1:0] w_slice;
    logic                 w_load;
    logic                 w_commit;

    // Rotating search starting at r_ptr; index wraps without a power-of-2 mask.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (IDW+1)'(k);
            if (w_idx >= (IDW+1)'(NUM_REQ))
                w_idx = w_idx - (IDW+1)'(NUM_REQ);
            if (!w_found && req[w_idx[IDW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[IDW-1:0];
            end
        end
    end

    always_comb begin
        w_ptr_inc  = {1'b0, r_hold_id} + (IDW+1)'(1);
        w_ptr_next = w_ptr_inc[IDW-1:0];
        if (w_ptr_inc >= (IDW+1)'(NUM_REQ))
            w_ptr_next = '0;
    end

    assign w_onehot = NUM_REQ'(1) << w_win;
    assign w_slice  = wr_data[w_win*DATAWIDTH +: DATAWIDTH];

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_commit     = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_load       = 1'b1;
                    w_next_state = S_WRITE;
                end
            end
            S_WRITE: begin
                w_commit     = 1'b1;
                w_next_state = S_IDLE;
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst)
            r_state <= S_IDLE;
        else
            r_state <= w_next_state;
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_ptr       <= '0;
            r_hold_id   <= '0;
            r_hold_data <= '0;
            r_grant     <= '0;
            r_q         <= '0;
            r_q_valid   <= 1'b0;
            r_last_id   <= '0;
        end else begin
            r_grant <= w_load ? w_onehot : '0;
            if (w_load) begin
                r_hold_id   <= w_win;
                r_hold_data <= w_slice;
            end
            if (w_commit) begin
                r_q       <= r_hold_data;
                r_last_id <= r_hold_id;
                r_q_valid <= 1'b1;
                r_ptr     <= w_ptr_next;
            end
        end
    end

    // ack is by definition the same pulse as grant.
    assign grant   = r_grant;
    assign ack     = r_grant;
    assign q       = r_q;
    assign q_valid = r_q_valid;
    assign last_id = r_last_id;
    assign busy    = (r_state == S_WRITE);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter with a cycle-level reference model.
module tb_reg_write_arbiter;

    localparam int N  = 4;
    localparam int DW = 8;

    logic            Clk;
    logic            Rst;
    logic [N-1:0]    req;
    logic [N*DW-1:0] wr_data;
    logic [N-1:0]    grant;
    logic [N-1:0]    ack;
    logic [DW-1:0]   q;
    logic            q_valid;
    logic [1:0]      last_id;
    logic            busy;

    int n_vec  = 0;
    int n_fail = 0;

    reg_write_arbiter #(.DATAWIDTH(DW), .NUM_REQ(N)) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .req     (req),
        .wr_data (wr_data),
        .grant   (grant),
        .ack     (ack),
        .q       (q),
        .q_valid (q_valid),
        .last_id (last_id),
        .busy    (busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: pending write held as (id, data), pointer as integer.
    int            m_ptr;
    bit            m_pending;
    int            m_id;
    logic [DW-1:0] m_data;
    logic [N-1:0]  e_grant;
    logic [DW-1:0] e_q;
    logic          e_qv;
    int            e_last;
    bit            m_en = 0;

    always @(posedge Clk) begin
        if (Rst) begin
            m_ptr = 0; m_pending = 0; m_id = 0; m_data = '0;
            e_grant = '0; e_q = '0; e_qv = 0; e_last = 0;
        end else if (m_pending) begin
            e_q = m_data; e_last = m_id; e_qv = 1;
            m_ptr = (m_id + 1) % N;
            m_pending = 0;
            e_grant = '0;
        end else begin
            e_grant = '0;
            for (int k = 0; k < N; k++) begin
                int w;
                w = (m_ptr + k) % N;
                if (!m_pending && req[w]) begin
                    m_pending = 1;
                    m_id = w;
                    m_data = wr_data[w*DW +: DW];
                    e_grant[w] = 1'b1;
                end
            end
        end
        m_en = 1;
    end

    always @(negedge Clk) begin
        if (m_en) begin
            n_vec++;
            if (grant !== e_grant || ack !== e_grant || q !== e_q ||
                q_valid !== e_qv || last_id !== 2'(e_last) ||
                busy !== m_pending) begin
                n_fail++;
                $display("FAIL model t=%0t act g=%b a=%b q=%h v=%b id=%0d b=%b exp g=%b q=%h v=%b id=%0d b=%b",
                         $time, grant, ack, q, q_valid, last_id, busy,
                         e_grant, e_q, e_qv, e_last, m_pending);
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    logic [N-1:0] pats [8] = '{4'b0101, 4'b0101, 4'b1000, 4'b0000,
                               4'b1110, 4'b1110, 4'b0001, 4'b1111};

    initial begin
        Rst = 1'b1;
        req = 4'b1111;
        wr_data = {8'h13, 8'h12, 8'h11, 8'h10};
        tick();
        check("rst1_grant", 32'(grant), 32'h0);
        check("rst1_q", 32'(q), 32'h0);
        tick();
        check("rst2_busy", 32'(busy), 32'h0);
        check("rst2_qv", 32'(q_valid), 32'h0);
        Rst = 1'b0;

        // Round robin under continuous requests.
        tick();
        check("rr_g0", 32'(grant), 32'h1);
        check("rr_a0", 32'(ack), 32'h1);
        tick();
        check("rr_q0", 32'(q), 32'h10);
        tick();
        check("rr_g1", 32'(grant), 32'h2);
        tick();
        check("rr_q1", 32'(q), 32'h11);
        tick();
        check("rr_g2", 32'(grant), 32'h4);
        tick();
        check("rr_q2", 32'(q), 32'h12);
        tick();
        check("rr_g3", 32'(grant), 32'h8);
        tick();
        check("rr_q3", 32'(q), 32'h13);
        tick();
        check("rr_g4", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();
        check("rr_q4", 32'(q), 32'h10);
        check("rr_id4", 32'(last_id), 32'h0);
        tick();

        // Single requester wins regardless of pointer.
        req = 4'b0100;
        wr_data[2*DW +: DW] = 8'hA5;
        tick();
        check("single_g", 32'(grant), 32'h4);
        check("single_busy", 32'(busy), 32'h1);
        req = 4'b0000;
        tick();
        check("single_q", 32'(q), 32'hA5);
        check("single_id", 32'(last_id), 32'h2);
        check("single_qv", 32'(q_valid), 32'h1);

        // Pointer at 3 wraps to 0, then 1.
        req = 4'b0011;
        wr_data[0 +: DW] = 8'h21;
        wr_data[DW +: DW] = 8'h22;
        tick();
        check("wrap_g0", 32'(grant), 32'h1);
        tick();
        check("wrap_q0", 32'(q), 32'h21);
        tick();
        check("wrap_g1", 32'(grant), 32'h2);
        req = 4'b0000;
        tick();
        check("wrap_q1", 32'(q), 32'h22);
        req = 4'b1011;
        tick();
        check("ptr2_skip", 32'(grant), 32'h8);
        req = 4'b0000;
        tick();

        // Captured data ignores later changes.
        req = 4'b0001;
        wr_data[0 +: DW] = 8'h3C;
        tick();
        check("cap_g", 32'(grant), 32'h1);
        wr_data[0 +: DW] = 8'hFF;
        req = 4'b0000;
        tick();
        check("cap_q", 32'(q), 32'h3C);
        tick();
        check("cap_nogrant", 32'(grant), 32'h0);
        check("cap_hold", 32'(q), 32'h3C);

        // Reset during WRITE abandons the write.
        req = 4'b0001;
        wr_data[0 +: DW] = 8'h77;
        tick();
        check("abort_g", 32'(grant), 32'h1);
        Rst = 1'b1;
        req = 4'b0000;
        tick();
        check("abort_q", 32'(q), 32'h0);
        check("abort_qv", 32'(q_valid), 32'h0);
        check("abort_ack", 32'(ack), 32'h0);
        Rst = 1'b0;
        req = 4'b1111;
        tick();
        check("abort_ptr0", 32'(grant), 32'h1);
        req = 4'b0000;
        tick();

        // Mixed pattern table checked by the model.
        for (int i = 0; i < 8; i++) begin
            req = pats[i];
            wr_data = {8'(8'h40 + i), 8'(8'h30 + i), 8'(8'h20 + i), 8'(8'h10 + i)};
            tick();
        end
        req = 4'b0000;
        tick();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
